cpu_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the team CPU. It generalises the fixed FETCH/DECODE/EXECUTE/WRITEBACK loop with:
- variable-latency handshakes on fetch, execute and memory
- an optional MEMORY stage
- single-step debug mode and resume-from-halt
- per-stage timeout trapping
- performance counters

It sits between the instruction memory, ALU and data-memory interfaces and drives the datapath stage enables through the `state` output.

---
 rtl/cpu_sequencer_if.sv | 49 ++++
 rtl/cpu_sequencer.sv | 142 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Opcode types and the sequencer's control/status bundle.
// master drives the control inputs, slave is the sequencer.
package opcodes;
  typedef logic [31:0] instruction_t;
  localparam instruction_t HALT = 32'h0010_0073;
endpackage

interface cpu_sequencer_if #(
  parameter int CNT_W = 32
) ();
  import opcodes::*;

  instruction_t     instr;
  logic             fetch_ready;
  logic             exec_done;
  logic             mem_op;
  logic             mem_ready;
  logic             step_mode;
  logic             step;
  logic             resume;
  logic             clear_counters;
  logic [2:0]       state;
  logic             retire;
  logic             halted;
  logic             trapped;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output instr, fetch_ready, exec_done,
    output mem_op, mem_ready,
    output step_mode, step, resume,
    output clear_counters,
    input  state, retire, halted, trapped,
    input  trap_cause, cycle_count,
    input  retire_count
  );

  modport slave (
    input  instr, fetch_ready, exec_done,
    input  mem_op, mem_ready,
    input  step_mode, step, resume,
    input  clear_counters,
    output state, retire, halted, trapped,
    output trap_cause, cycle_count,
    output retire_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer with wait
// timeouts, single-step, halt/resume and perf counters.
module cpu_sequencer
  import opcodes::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int STEP_EN = 1
) (
  input logic           clk,
  input logic           rst,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_PAUSED    = 3'd6,
    S_TRAP      = 3'd7
  } state_e;

  localparam int WAIT_W =
    (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ret_q, ret_d;

  logic       waiting;
  logic       stage_ready;
  logic [1:0] stage_code;
  logic       timeout;
  logic       active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= 2'd0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    waiting     = 1'b0;
    stage_ready = 1'b0;
    stage_code  = 2'd0;
    unique case (state_q)
      S_FETCH: begin
        waiting     = 1'b1;
        stage_ready = bus.fetch_ready;
        stage_code  = 2'd1;
        if (bus.fetch_ready)
          state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        waiting     = 1'b1;
        stage_ready = bus.exec_done;
        stage_code  = 2'd2;
        if (bus.exec_done)
          state_d = bus.mem_op ? S_MEMORY
                               : S_WRITEBACK;
      end
      S_MEMORY: begin
        waiting     = 1'b1;
        stage_ready = bus.mem_ready;
        stage_code  = 2'd3;
        if (bus.mem_ready)
          state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (bus.instr == HALT)
          state_d = S_HALTED;
        else if (bus.step_mode && STEP_EN != 0)
          state_d = S_PAUSED;
        else
          state_d = S_FETCH;
      end
      S_PAUSED: if (bus.step)   state_d = S_FETCH;
      S_HALTED: if (bus.resume) state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
    // ready on the last allowed wait cycle still wins
    timeout = (TIMEOUT > 0) && waiting &&
              !stage_ready && (wait_q == WAIT_LAST);
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = stage_code;
    end
    if (state_d != state_q)
      wait_d = '0;
    else if (waiting)
      wait_d = wait_q + 1'b1;
    else
      wait_d = '0;
  end

  always_comb begin
    active = !(state_q inside
               {S_HALTED, S_PAUSED, S_TRAP});
    cyc_d  = cyc_q;
    ret_d  = ret_q;
    if (bus.clear_counters) begin
      cyc_d = '0;
      ret_d = '0;
    end else begin
      if (active && !(&cyc_q))
        cyc_d = cyc_q + 1'b1;
      if (state_q == S_WRITEBACK && !(&ret_q))
        ret_d = ret_q + 1'b1;
    end
  end

  always_comb begin
    bus.state        = state_q;
    bus.retire       = (state_q == S_WRITEBACK);
    bus.halted       = (state_q == S_HALTED);
    bus.trapped      = (state_q == S_TRAP);
    bus.trap_cause   = cause_q;
    bus.cycle_count  = cyc_q;
    bus.retire_count = ret_q;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two builds driven in
// lockstep, each checked against a behavioural model.
module tb_cpu_sequencer;
  import opcodes::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  instruction_t instr = '0;
  logic fr = 0, ed = 0, mop = 0, mrdy = 0;
  logic smode = 0, stp = 0, res = 0, clr = 0;
  bit armed = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.CNT_W(4))  if_a ();
  cpu_sequencer_if #(.CNT_W(32)) if_b ();

  assign if_a.instr = instr;
  assign if_a.fetch_ready = fr;
  assign if_a.exec_done = ed;
  assign if_a.mem_op = mop;
  assign if_a.mem_ready = mrdy;
  assign if_a.step_mode = smode;
  assign if_a.step = stp;
  assign if_a.resume = res;
  assign if_a.clear_counters = clr;
  assign if_b.instr = instr;
  assign if_b.fetch_ready = fr;
  assign if_b.exec_done = ed;
  assign if_b.mem_op = mop;
  assign if_b.mem_ready = mrdy;
  assign if_b.step_mode = smode;
  assign if_b.step = stp;
  assign if_b.resume = res;
  assign if_b.clear_counters = clr;

  cpu_sequencer #(
    .CNT_W(4), .TIMEOUT(4), .STEP_EN(1)
  ) dut_a (.clk(clk), .rst(rst_n), .bus(if_a));

  cpu_sequencer #(
    .CNT_W(32), .TIMEOUT(16), .STEP_EN(0)
  ) dut_b (.clk(clk), .rst(rst_n), .bus(if_b));

  typedef struct {
    int     st;
    int     wt;
    int     cause;
    longint cyc;
    longint ret;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_next(
    mdl_t m, int tmo, bit sen, longint cmax);
    mdl_t n;
    bit rdy;
    int code;
    int nxt;
    bit stall_stage;
    n = m;
    if (!rst_n) begin
      n = '{0, 0, 0, 0, 0};
      return n;
    end
    if (clr) begin
      n.cyc = 0;
      n.ret = 0;
    end else begin
      if (!(m.st inside {5, 6, 7}) && m.cyc < cmax)
        n.cyc = m.cyc + 1;
      if (m.st == 4 && m.ret < cmax)
        n.ret = m.ret + 1;
    end
    rdy = 0;
    code = 0;
    nxt = m.st;
    stall_stage = m.st inside {0, 2, 3};
    case (m.st)
      0: begin rdy = fr; code = 1;
        if (fr) nxt = 1; end
      1: nxt = 2;
      2: begin rdy = ed; code = 2;
        if (ed) nxt = mop ? 3 : 4; end
      3: begin rdy = mrdy; code = 3;
        if (mrdy) nxt = 4; end
      4: begin
        if (instr == HALT) nxt = 5;
        else if (smode && sen) nxt = 6;
        else nxt = 0;
      end
      5: if (res) nxt = 0;
      6: if (stp) nxt = 0;
      default: nxt = 7;
    endcase
    // the TIMEOUT-th consecutive idle cycle traps
    if (stall_stage && !rdy && tmo > 0 &&
        m.wt + 1 >= tmo) begin
      nxt = 7;
      n.cause = code;
    end
    if (nxt != m.st) n.wt = 0;
    else if (stall_stage) n.wt = m.wt + 1;
    else n.wt = 0;
    n.st = nxt;
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= mdl_next(ma, 4, 1'b1, 64'd15);
    mb <= mdl_next(mb, 16, 1'b0, 64'hFFFF_FFFF);
  end

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("a_state", 64'(if_a.state), 64'(ma.st));
      chk("a_retire", 64'(if_a.retire),
          64'(ma.st == 4));
      chk("a_halted", 64'(if_a.halted),
          64'(ma.st == 5));
      chk("a_trapped", 64'(if_a.trapped),
          64'(ma.st == 7));
      chk("a_cause", 64'(if_a.trap_cause),
          64'(ma.cause));
      chk("a_cyc", 64'(if_a.cycle_count), ma.cyc);
      chk("a_ret", 64'(if_a.retire_count), ma.ret);
      chk("b_state", 64'(if_b.state), 64'(mb.st));
      chk("b_retire", 64'(if_b.retire),
          64'(mb.st == 4));
      chk("b_trapped", 64'(if_b.trapped),
          64'(mb.st == 7));
      chk("b_cause", 64'(if_b.trap_cause),
          64'(mb.cause));
      chk("b_cyc", 64'(if_b.cycle_count), mb.cyc);
      chk("b_ret", 64'(if_b.retire_count), mb.ret);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    tick(1);
    armed = 1;
    tick(1);
    chk("rst_state", 64'(if_a.state), 64'd0);
    chk("rst_cyc", 64'(if_a.cycle_count), 64'd0);
    chk("rst_cause", 64'(if_a.trap_cause), 64'd0);
    rst_n = 1'b1;

    // three back-to-back ALU instructions
    fr = 1; ed = 1; mop = 0;
    tick(12);
    chk("t1_ret", 64'(if_a.retire_count), 64'd3);
    chk("t1_cyc", 64'(if_a.cycle_count), 64'd12);
    chk("t1_state", 64'(if_a.state), 64'd0);

    // memory op with three wait cycles
    do_reset();
    mop = 1; mrdy = 0;
    tick(6);
    chk("t2_mem", 64'(if_a.state), 64'd3);
    mrdy = 1;
    tick(2);
    chk("t2_cyc", 64'(if_b.cycle_count), 64'd8);
    chk("t2_cyc_a", 64'(if_a.cycle_count), 64'd8);
    chk("t2_notrap", 64'(if_a.trapped), 64'd0);
    mop = 0;

    // execute timeout and recovery
    do_reset();
    ed = 0;
    tick(6);
    chk("t3_trap", 64'(if_a.state), 64'd7);
    chk("t3_cause", 64'(if_a.trap_cause), 64'd2);
    ed = 1;
    tick(3);
    chk("t3_sticky", 64'(if_a.state), 64'd7);
    do_reset();
    chk("t3_rst", 64'(if_a.state), 64'd0);
    chk("t3_rst_c", 64'(if_a.trap_cause), 64'd0);
    ed = 0;
    tick(5);
    ed = 1;
    tick(1);
    chk("t3_edge", 64'(if_a.state), 64'd4);

    // fetch and memory timeouts
    do_reset();
    fr = 0;
    tick(4);
    chk("t3_fcause", 64'(if_a.trap_cause), 64'd1);
    do_reset();
    fr = 1; mop = 1; mrdy = 0;
    tick(7);
    chk("t3_mcause", 64'(if_a.trap_cause), 64'd3);
    mop = 0; mrdy = 1;

    // HALT beats step_mode
    do_reset();
    instr = HALT; smode = 1;
    tick(4);
    chk("t4_halt", 64'(if_a.state), 64'd5);
    chk("t4_hflag", 64'(if_a.halted), 64'd1);
    stp = 1;
    tick(1);
    stp = 0;
    tick(2);
    chk("t4_stay", 64'(if_a.state), 64'd5);
    chk("t4_frz", 64'(if_a.cycle_count), 64'd4);
    chk("t4_ret", 64'(if_a.retire_count), 64'd1);
    instr = '0;
    res = 1;
    tick(1);
    res = 0;
    chk("t4_res", 64'(if_a.state), 64'd0);

    // single-step pauses, idle cycles uncounted
    do_reset();
    tick(4);
    chk("t5_pause", 64'(if_a.state), 64'd6);
    chk("t5_nostep", 64'(if_b.state), 64'd0);
    tick(5);
    chk("t5_cyc", 64'(if_a.cycle_count), 64'd4);
    chk("t5_cyc_b", 64'(if_b.cycle_count), 64'd9);
    res = 1;
    tick(1);
    res = 0;
    chk("t5_resign", 64'(if_a.state), 64'd6);
    stp = 1;
    tick(1);
    stp = 0;
    chk("t5_step", 64'(if_a.state), 64'd0);
    smode = 0;

    // saturation then clear on a retire cycle
    do_reset();
    tick(80);
    chk("t6_sat_r", 64'(if_a.retire_count), 64'd15);
    chk("t6_sat_c", 64'(if_a.cycle_count), 64'd15);
    chk("t6_b_ret", 64'(if_b.retire_count), 64'd20);
    tick(3);
    chk("t6_wb", 64'(if_a.retire), 64'd1);
    clr = 1;
    tick(1);
    clr = 0;
    chk("t6_clr_r", 64'(if_a.retire_count), 64'd0);
    chk("t6_clr_c", 64'(if_a.cycle_count), 64'd0);
    chk("t6_clr_b", 64'(if_b.retire_count), 64'd0);

    tick(2);
    armed = 0;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
